// File: rtl/busca_instrucao_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the memory (slave).
interface busca_instrucao_if;
  logic [7:0] MemEnd;
  logic       MemLer;
  logic       MemPronto;
  logic [7:0] MemDado;

  modport master (
    output MemEnd,
    output MemLer,
    input  MemPronto,
    input  MemDado
  );

  modport slave (
    input  MemEnd,
    input  MemLer,
    output MemPronto,
    output MemDado
  );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch unit: latches the PC, requests one word, holds it for the decoder.
// Optional fetch timeout with sticky error state enabled by defining BUSCA_TIMEOUT_EN.

// state   | meaning
// ESPERA  | one settle cycle for the PC; address latched at its end
// PEDINDO | read request outstanding, MemEnd held stable
// CHEIO   | Instrucao valid, waiting for Avanca or Desvio
// ERRO    | memory never answered; left only by reset (BUSCA_TIMEOUT_EN)
module busca_instrucao #(
  parameter int LIMITE_ESPERA = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        Endereco,
  output logic              EscPC,
  busca_instrucao_if.master mem,
  output logic [7:0]        Instrucao,
  output logic              InstrValida,
  input  logic              Avanca,
  input  logic              Desvio,
  output logic              ErroBusca
);

  localparam logic [1:0] ESPERA  = 2'd0;
  localparam logic [1:0] PEDINDO = 2'd1;
  localparam logic [1:0] CHEIO   = 2'd2;
  localparam logic [1:0] ERRO    = 2'd3;

  logic [1:0] estado_q, estado_d;
  logic [7:0] end_q, end_d;
  logic [7:0] instr_q, instr_d;
  logic       valida_q, valida_d;
  logic       escpc_q, escpc_d;
  logic       descarta_q, descarta_d;

`ifdef BUSCA_TIMEOUT_EN
  localparam int CW = (LIMITE_ESPERA > 2) ? $clog2(LIMITE_ESPERA) : 1;
  localparam logic [CW-1:0] CARGA = CW'(LIMITE_ESPERA - 1);

  logic [CW-1:0] cont_q, cont_d;
  logic          erro_q, erro_d;
`endif

  always_comb begin
    estado_d   = estado_q;
    end_d      = end_q;
    instr_d    = instr_q;
    valida_d   = valida_q;
    escpc_d    = 1'b0;
    descarta_d = descarta_q;
`ifdef BUSCA_TIMEOUT_EN
    cont_d     = cont_q;
    erro_d     = erro_q;
`endif
    case (estado_q)
      ESPERA: begin
        end_d      = Endereco;
        descarta_d = 1'b0;
        estado_d   = PEDINDO;
`ifdef BUSCA_TIMEOUT_EN
        cont_d     = CARGA;
`endif
      end
      PEDINDO: begin
        if (mem.MemPronto) begin
          // a branch seen during or on the ack cycle makes this word stale
          if (descarta_q || Desvio) begin
            descarta_d = 1'b0;
            estado_d   = ESPERA;
          end else begin
            instr_d  = mem.MemDado;
            valida_d = 1'b1;
            escpc_d  = 1'b1;
            estado_d = CHEIO;
          end
        end else begin
          if (Desvio) begin
            descarta_d = 1'b1;
          end
`ifdef BUSCA_TIMEOUT_EN
          if (cont_q == '0) begin
            erro_d   = 1'b1;
            estado_d = ERRO;
          end else begin
            cont_d = cont_q - 1'b1;
          end
`endif
        end
      end
      CHEIO: begin
        if (Desvio || Avanca) begin
          valida_d = 1'b0;
          estado_d = ESPERA;
        end
      end
`ifdef BUSCA_TIMEOUT_EN
      ERRO: begin
        estado_d = ERRO;
      end
`endif
      default: begin
        estado_d = ESPERA;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q   <= ESPERA;
      end_q      <= 8'h00;
      instr_q    <= 8'h00;
      valida_q   <= 1'b0;
      escpc_q    <= 1'b0;
      descarta_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      end_q      <= end_d;
      instr_q    <= instr_d;
      valida_q   <= valida_d;
      escpc_q    <= escpc_d;
      descarta_q <= descarta_d;
    end
  end

`ifdef BUSCA_TIMEOUT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cont_q <= '0;
      erro_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      erro_q <= erro_d;
    end
  end

  assign ErroBusca = erro_q;
`else
  assign ErroBusca = 1'b0;
`endif

  assign mem.MemEnd  = end_q;
  assign mem.MemLer  = (estado_q == PEDINDO);
  assign EscPC       = escpc_q;
  assign Instrucao   = instr_q;
  assign InstrValida = valida_q;

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter LIMITE_ESPERA, default 15: cycles PEDINDO waits for MemPronto before fault (used only with BUSCA_TIMEOUT_EN).
REQ-002 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Endereco  input  8  current program-counter output (PC read side).
REQ-005 SHALL have port EscPC  output  1  one-cycle PC write-enable pulse requesting sequential PC advance.
REQ-006 SHALL have port MemEnd  output  8  instruction-memory read address.
REQ-007 SHALL have port MemLer  output  1  instruction-memory read request.
REQ-008 SHALL have port MemPronto  input  1  memory acknowledge; MemDado valid in the same cycle.
REQ-009 SHALL have port MemDado  input  8  instruction word from memory.
REQ-010 SHALL have port Instrucao  output  8  registered fetched instruction.
REQ-011 SHALL have port InstrValida  output  1  Instrucao holds a valid, unconsumed instruction.
REQ-012 SHALL have port Avanca  input  1  decoder consumes Instrucao on a cycle where InstrValida=1.
REQ-013 SHALL have port Desvio  input  1  branch flush; the branch unit owns the PC write that cycle.
REQ-014 SHALL have port ErroBusca  output  1  sticky fetch-timeout flag.

Function
REQ-015 SHALL implement FSM states ESPERA, PEDINDO, CHEIO, plus ERRO when BUSCA_TIMEOUT_EN is defined.
REQ-016 ESPERA SHALL last exactly one cycle, keep MemLer=0, and at the next edge latch Endereco into MemEnd and enter PEDINDO (allows PC output to settle after its capture/output split).
REQ-017 PEDINDO SHALL hold MemLer=1 and MemEnd stable until a cycle with MemPronto=1.
REQ-018 On MemPronto in PEDINDO (no pending discard): capture MemDado into Instrucao, set InstrValida, drive EscPC=1 for the following cycle only, enter CHEIO.
REQ-019 MemLer SHALL drop in the cycle after MemPronto is sampled; MemPronto outside PEDINDO SHALL be ignored.
REQ-020 CHEIO SHALL hold Instrucao and InstrValida=1 unchanged until Avanca=1, then clear InstrValida and enter ESPERA.
REQ-021 Best-case throughput: one instruction per 3 cycles with single-cycle memory (ESPERA, PEDINDO, CHEIO).
REQ-022 Desvio in CHEIO SHALL clear InstrValida and enter ESPERA; Desvio with Avanca in the same cycle behaves identically (Desvio dominant).
REQ-023 Desvio in PEDINDO SHALL set a discard flag; the request is not cancelled; on MemPronto with flag set, data is dropped, EscPC stays 0, flag clears, state goes to ESPERA.
REQ-024 Desvio on the MemPronto cycle itself SHALL be treated as REQ-023 (drop data, no EscPC).
REQ-025 Desvio in ESPERA SHALL have no effect (address not yet latched).
REQ-026 EscPC SHALL never be high for two consecutive cycles.

Reset
REQ-027 Reset=0 SHALL asynchronously force state ESPERA, MemEnd=8'h00, MemLer=0, EscPC=0, Instrucao=8'h00, InstrValida=0, ErroBusca=0, discard flag and timeout counter cleared.
REQ-028 Reset asserted mid-request SHALL abandon the request; a late MemPronto after release SHALL be ignored unless in PEDINDO.
REQ-029 First MemLer after reset release SHALL assert in the second cycle after release.

Configuration
REQ-030 Macro BUSCA_TIMEOUT_EN defined: counter increments each PEDINDO cycle without MemPronto; at LIMITE_ESPERA it enters ERRO, MemLer=0, ErroBusca=1; ERRO exits only by reset.
REQ-031 Macro BUSCA_TIMEOUT_EN undefined: no counter, no ERRO state, PEDINDO waits indefinitely, ErroBusca tied 0.

Verification
REQ-032 Reset release, Endereco=8'h00, MemPronto 1 cycle after MemLer, MemDado=8'hA5 -> MemEnd=8'h00, Instrucao=8'hA5, InstrValida=1, one EscPC pulse.
REQ-033 Avanca held high, PC increments on EscPC, single-cycle memory -> addresses 00,01,02 fetched, one instruction per 3 cycles, no double EscPC.
REQ-034 MemPronto delayed 5 cycles -> MemLer and MemEnd stable 6 cycles, InstrValida rises only after ack.
REQ-035 Desvio during PEDINDO, PC forced to 8'h40 -> first ack dropped, no EscPC, next MemEnd=8'h40.
REQ-036 With BUSCA_TIMEOUT_EN, LIMITE_ESPERA=15, MemPronto never asserted -> ErroBusca=1 after 15 PEDINDO cycles, MemLer=0 until reset; without macro -> MemLer stays high, ErroBusca=0.
REQ-037 Reset pulsed low during CHEIO with Instrucao=8'h3C -> InstrValida=0, Instrucao=8'h00 immediately, fetch restarts per REQ-029.
